// File: rtl/regfile_mp_if.sv
// Bundle of read, write, claim and scoreboard signals for regfile_mp.
// master drives addresses/writes/claims; slave is the register file.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 3
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pending;
    logic                     we0;
    logic [ADDR_W-1:0]        waddr0;
    logic [DATA_W-1:0]        wdata0;
    logic                     we1;
    logic [ADDR_W-1:0]        waddr1;
    logic [DATA_W-1:0]        wdata1;
    logic                     claim_en;
    logic [ADDR_W-1:0]        claim_addr;
    logic [ADDR_W:0]          pending_cnt;

    modport master (
        output rd_addr, we0, waddr0, wdata0,
        output we1, waddr1, wdata1,
        output claim_en, claim_addr,
        input  rd_data, rd_pending, pending_cnt
    );

    modport slave (
        input  rd_addr, we0, waddr0, wdata0,
        input  we1, waddr1, wdata1,
        input  claim_en, claim_addr,
        output rd_data, rd_pending, pending_cnt
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD reads, two prioritised writes, pending scoreboard.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [CNT_W-1:0]  r_cnt;

    logic [DEPTH-1:0]  w_pend_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_wr0;
    logic              w_wr1;
    logic              w_wr0_win;

    function automatic logic f_writable(input logic [ADDR_W-1:0] a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign w_wr0     = bus.we0 && f_writable(bus.waddr0);
    assign w_wr1     = bus.we1 && f_writable(bus.waddr1);
    assign w_wr0_win = w_wr0 && !(w_wr1 && (bus.waddr1 == bus.waddr0));

    // Any write clears its target, even a losing one; a claim overrides.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int a = 0; a < DEPTH; a++) begin
            if ((bus.we0 && (bus.waddr0 == ADDR_W'(a))) ||
                (bus.we1 && (bus.waddr1 == ADDR_W'(a))))
                w_pend_nxt[a] = 1'b0;
            if (bus.claim_en && (bus.claim_addr == ADDR_W'(a)))
                w_pend_nxt[a] = 1'b1;
        end
        if (ZERO_REG != 0)
            w_pend_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int a = 0; a < DEPTH; a++)
            w_cnt_nxt = w_cnt_nxt + CNT_W'(w_pend_nxt[a]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int a = 0; a < DEPTH; a++)
                r_mem[a] <= '0;
        end else begin
            if (w_wr0_win)
                r_mem[bus.waddr0] <= bus.wdata0;
            if (w_wr1)
                r_mem[bus.waddr1] <= bus.wdata1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    always_comb begin
        bus.rd_data    = '0;
        bus.rd_pending = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            automatic logic [ADDR_W-1:0] w_ra;
            automatic logic [DATA_W-1:0] w_rd;
            automatic logic              w_rp;
            w_ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
            w_rd = r_mem[w_ra];
            w_rp = r_pend[w_ra];
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_rd = '0;
                w_rp = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            if (reset && w_wr1 && (bus.waddr1 == w_ra)) begin
                w_rd = bus.wdata1;
                w_rp = bus.claim_en && (bus.claim_addr == w_ra);
            end else if (reset && w_wr0 && (bus.waddr0 == w_ra)) begin
                w_rd = bus.wdata0;
                w_rp = bus.claim_en && (bus.claim_addr == w_ra);
            end
`endif
            bus.rd_data[k*DATA_W +: DATA_W] = w_rd;
            bus.rd_pending[k]               = w_rp;
        end
    end

    assign bus.pending_cnt = r_cnt;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp (default parameters).
// Expected values are queued at drive time and drained after each edge.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        string       tag;
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3)) bus ();

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_obs(input int kind, input int port);
        case (kind)
            0:       return bus.rd_data[port*32 +: 32];
            1:       return {31'b0, bus.rd_pending[port]};
            default: return 32'(bus.pending_cnt);
        endcase
    endfunction

    task automatic push(input string tag, input int kind,
                        input int port, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.kind = kind; e.port = port; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = f_obs(e.kind, e.port);
            checks++;
            assert (o === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic set_rd(input int k, input logic [4:0] a);
        bus.rd_addr[k*5 +: 5] = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.we0 = 1'b0;
        bus.we1 = 1'b0;
        bus.claim_en = 1'b0;
        drain();
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        bus.we0 = 1'b1; bus.waddr0 = a; bus.wdata0 = d;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d);
        bus.we1 = 1'b1; bus.waddr1 = a; bus.wdata1 = d;
    endtask

    task automatic claim(input logic [4:0] a);
        bus.claim_en = 1'b1; bus.claim_addr = a;
    endtask

    initial begin
        bus.rd_addr = '0;
        bus.we0 = 1'b0; bus.waddr0 = '0; bus.wdata0 = '0;
        bus.we1 = 1'b0; bus.waddr1 = '0; bus.wdata1 = '0;
        bus.claim_en = 1'b0; bus.claim_addr = '0;
        #1;
        set_rd(0, 5);
        set_rd(1, 6);
        #1;
        push("rst_data", 0, 0, 32'h0);
        push("rst_pend", 1, 1, 32'h0);
        push("rst_cnt", 2, 0, 32'h0);
        drain();
        #1 reset = 1'b1;
        tick();

        wr0(5, 32'hDEADBEEF);
        claim(6);
        push("wr_r5", 0, 0, 32'hDEADBEEF);
        push("claim_r6", 1, 1, 32'h1);
        push("cnt_r6", 2, 0, 32'h1);
        tick();

        #2 reset = 1'b0;
        #1;
        push("async_rst_r5", 0, 0, 32'h0);
        push("async_rst_pend", 1, 1, 32'h0);
        push("async_rst_cnt", 2, 0, 32'h0);
        drain();
        #2 reset = 1'b1;

        wr0(5, 32'h0BADF00D);
        push("post_rst_r5", 0, 0, 32'h0BADF00D);
        tick();

        set_rd(0, 3);
        set_rd(1, 4);
        wr0(3, 32'h11111111);
        wr1(4, 32'h22222222);
        push("dual_r3", 0, 0, 32'h11111111);
        push("dual_r4", 0, 1, 32'h22222222);
        tick();

        set_rd(2, 7);
        claim(7);
        push("claim_r7", 1, 2, 32'h1);
        push("cnt_r7", 2, 0, 32'h1);
        tick();

        wr0(7, 32'hAAAA0000);
        wr1(7, 32'h0000BBBB);
        push("coll_r7", 0, 2, 32'h0000BBBB);
        push("coll_pend", 1, 2, 32'h0);
        push("coll_cnt", 2, 0, 32'h0);
        tick();

        set_rd(0, 0);
        wr1(0, 32'hFFFFFFFF);
        claim(0);
        push("zero_data", 0, 0, 32'h0);
        push("zero_pend", 1, 0, 32'h0);
        push("zero_cnt", 2, 0, 32'h0);
        tick();

        set_rd(1, 9);
        set_rd(2, 10);
        claim(9);
        push("sb_pend9", 1, 1, 32'h1);
        push("sb_cnt1", 2, 0, 32'h1);
        tick();

        claim(10);
        push("sb_pend10", 1, 2, 32'h1);
        push("sb_cnt2", 2, 0, 32'h2);
        tick();

        wr0(9, 32'h00000099);
        claim(9);
        push("sb_wr9_data", 0, 1, 32'h00000099);
        push("sb_wr9_pend", 1, 1, 32'h1);
        push("sb_wr9_cnt", 2, 0, 32'h2);
        tick();

        wr1(10, 32'h000000A0);
        push("sb_wr10_pend", 1, 2, 32'h0);
        push("sb_wr10_cnt", 2, 0, 32'h1);
        tick();

        set_rd(0, 12);
        set_rd(1, 12);
        set_rd(2, 12);
        wr0(12, 32'hCAFE0000);
        push("byp_init", 0, 0, 32'hCAFE0000);
        tick();

        wr0(12, 32'h12345678);
        #1;
        for (int k = 0; k < 3; k++) begin
`ifdef REGFILE_BYPASS_EN
            push("byp_same_cycle", 0, k, 32'h12345678);
`else
            push("byp_same_cycle", 0, k, 32'hCAFE0000);
`endif
        end
        drain();
        for (int k = 0; k < 3; k++)
            push("byp_after_edge", 0, k, 32'h12345678);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
